axi_mem_slave_ooo: RTL and testbench

- Synthesizable successor to the behavioural memory slave, used as DUT in the AXI-lite bench.
- Word-addressed on-chip memory with byte strobes and bounded per-ID read queues.
- Reads complete out of order across IDs, with round-robin response arbitration; writes return ID-tagged B responses.
- Out-of-range accesses return SLVERR.

---
 rtl/axi_slv_pkg.sv | 22 ++
 rtl/axi_mem_slave_ooo_if.sv | 44 ++++
 rtl/axi_slv_fifo.sv | 49 ++++
 rtl/axi_mem_slave_ooo.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_mem_slave_ooo.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_slv_pkg.sv
// Shared types and helpers for the out-of-order AXI memory slave.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package axi_slv_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, expressed as a mask over bits [15:0].
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Byte address to word index; kept 64 bits wide so out-of-range
    // addresses never alias back into the memory before the range check.
    function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                                input int unsigned byte_shift);
        return addr >> byte_shift;
    endfunction

endpackage

// File: rtl/axi_mem_slave_ooo_if.sv
// AR/AW/W/R/B signal bundle between the bench master and the memory slave.
// Latency: n/a (wires only).
// Backpressure: valid/ready on every channel.
interface axi_mem_slave_ooo_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [ID_WIDTH-1:0]     arid;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [ID_WIDTH-1:0]     awid;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [ID_WIDTH-1:0]     rid;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arid, arvalid, awaddr, awid, awvalid,
               wdata, wstrb, wvalid, rready, bready,
        input  arready, awready, wready, rdata, rid, rresp, rvalid,
               bid, bresp, bvalid
    );

    modport slave (
        input  araddr, arid, arvalid, awaddr, awid, awvalid,
               wdata, wstrb, wvalid, rready, bready,
        output arready, awready, wready, rdata, rid, rresp, rvalid,
               bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_slv_fifo.sv
// Synchronous FIFO with show-ahead output; push when full / pop when empty are ignored.
// Latency: a pushed entry is visible on o_dout the cycle after the push edge.
// Backpressure: o_full / o_empty; callers gate push/pop on them.
module axi_slv_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    // Storage array; contents are don't-care while empty so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end
endmodule

// File: rtl/axi_mem_slave_ooo.sv
// Word memory slave: per-ID read queues with round-robin R arbitration, ID-tagged B queue, SLVERR out of range.
// Latency: R valid one edge after AR accept; AW+W commit next edge, B valid one edge after commit.
// Backpressure: arready per-ID queue space; full B queue stalls commit and AW/W holding regs. AXI_SLV_BACKPRESSURE_EN adds LFSR throttling.
module axi_mem_slave_ooo
    import axi_slv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 64,
    parameter int RQ_DEPTH   = 2,
    parameter int BQ_DEPTH   = 4
) (
    input logic                clk,
    input logic                rst,
    axi_mem_slave_ooo_if.slave bus
);
    localparam int N_IDS      = 2**ID_WIDTH;
    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam int IDX_W      = $clog2(MEM_WORDS);
    localparam int RQ_W       = DATA_WIDTH + 2;
    localparam int BQ_W       = ID_WIDTH + 2;

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    // Ready throttling (all-ones unless the LFSR feature is built in).
    logic w_ar_gate, w_aw_gate, w_w_gate, w_rd_en;

`ifdef AXI_SLV_BACKPRESSURE_EN
    logic [15:0] r_lfsr;

    // Free-running LFSR used to pseudo-randomly drop readies and stall R loads.
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end

    assign w_ar_gate = |r_lfsr[1:0];
    assign w_aw_gate = |r_lfsr[3:2];
    assign w_w_gate  = |r_lfsr[5:4];
    assign w_rd_en   = !r_lfsr[15];
`else
    assign w_ar_gate = 1'b1;
    assign w_aw_gate = 1'b1;
    assign w_w_gate  = 1'b1;
    assign w_rd_en   = 1'b1;
`endif

    // ---------------- AR -> per-ID read queues ----------------
    logic [ADDR_WIDTH-1:0] w_araddr;
    logic [63:0]           w_ar_idx;
    logic                  w_ar_err;
    logic [DATA_WIDTH-1:0] w_ar_word;
    logic                  w_ar_fire;
    logic [N_IDS-1:0]      w_rq_push, w_rq_pop, w_rq_full, w_rq_empty;
    logic [RQ_W-1:0]       w_rq_dout [N_IDS];
    resp_t                 w_ar_resp;

    assign w_araddr    = bus.araddr;
    assign w_ar_idx    = addr_to_idx(64'(w_araddr), BYTE_SHIFT);
    assign w_ar_err    = (w_ar_idx >= 64'(MEM_WORDS));
    // Combinational read of the array: a same-edge write commit lands after this sample.
    assign w_ar_word   = w_ar_err ? '0 : r_mem[w_ar_idx[IDX_W-1:0]];
    assign w_ar_resp   = w_ar_err ? RESP_SLVERR : RESP_OKAY;
    assign bus.arready = !w_rq_full[bus.arid] && w_ar_gate;
    assign w_ar_fire   = bus.arvalid && bus.arready;

    // ---------------- R arbitration ----------------
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ID_WIDTH-1:0]   r_rid;
    resp_t                 r_rresp;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [ID_WIDTH-1:0]   w_r_grant;
    logic                  w_r_found;
    logic                  w_r_load;
    logic                  w_r_pop;

    for (genvar g = 0; g < N_IDS; g++) begin : g_rq
        assign w_rq_push[g] = w_ar_fire && (bus.arid == ID_WIDTH'(g));
        assign w_rq_pop[g]  = w_r_pop && (w_r_grant == ID_WIDTH'(g));

        axi_slv_fifo #(
            .WIDTH (RQ_W),
            .DEPTH (RQ_DEPTH)
        ) u_rq (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_rq_push[g]),
            .i_din   ({w_ar_word, w_ar_resp}),
            .i_pop   (w_rq_pop[g]),
            .o_dout  (w_rq_dout[g]),
            .o_full  (w_rq_full[g]),
            .o_empty (w_rq_empty[g])
        );
    end

    // Pick the first non-empty read queue at or after the round-robin pointer, with wrap.
    always_comb begin
        w_r_found = 1'b0;
        w_r_grant = '0;
        for (int i = 0; i < N_IDS; i++) begin
            if (!w_r_found && !w_rq_empty[r_rr_ptr + ID_WIDTH'(i)]) begin
                w_r_found = 1'b1;
                w_r_grant = r_rr_ptr + ID_WIDTH'(i);
            end
        end
    end

    assign w_r_load = !r_rvalid || bus.rready;
    assign w_r_pop  = w_r_load && w_r_found && w_rd_en;

    // R output register: reload when free or consumed; hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
            r_rresp  <= RESP_OKAY;
            r_rr_ptr <= '0;
        end else if (w_r_load) begin
            r_rvalid <= w_r_pop;
            if (w_r_pop) begin
                r_rdata  <= w_rq_dout[w_r_grant][RQ_W-1:2];
                r_rresp  <= resp_t'(w_rq_dout[w_r_grant][1:0]);
                r_rid    <= w_r_grant;
                r_rr_ptr <= w_r_grant + ID_WIDTH'(1);
            end
        end
    end

    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;
    assign bus.rid    = r_rid;
    assign bus.rresp  = r_rresp;

    // ---------------- AW/W holding and write commit ----------------
    logic                  r_aw_full, r_w_full;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [ID_WIDTH-1:0]   r_aw_id;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [STRB_W-1:0]     r_w_strb;
    logic                  w_aw_fire, w_w_fire, w_commit;
    logic [63:0]           w_aw_idx;
    logic                  w_aw_err;
    logic                  w_bq_full, w_bq_empty, w_b_pop;
    logic [BQ_W-1:0]       w_bq_dout;
    resp_t                 w_aw_resp;

    assign bus.awready = !r_aw_full && w_aw_gate;
    assign bus.wready  = !r_w_full && w_w_gate;
    assign w_aw_fire   = bus.awvalid && bus.awready;
    assign w_w_fire    = bus.wvalid && bus.wready;
    assign w_commit    = r_aw_full && r_w_full && !w_bq_full;
    assign w_aw_idx    = addr_to_idx(64'(r_aw_addr), BYTE_SHIFT);
    assign w_aw_err    = (w_aw_idx >= 64'(MEM_WORDS));
    assign w_aw_resp   = w_aw_err ? RESP_SLVERR : RESP_OKAY;

    // AW and W holding registers fill independently and empty together on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_aw_id   <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
        end else begin
            if (w_aw_fire) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= bus.awaddr;
                r_aw_id   <= bus.awid;
            end else if (w_commit) begin
                r_aw_full <= 1'b0;
            end
            if (w_w_fire) begin
                r_w_full <= 1'b1;
                r_w_data <= bus.wdata;
                r_w_strb <= bus.wstrb;
            end else if (w_commit) begin
                r_w_full <= 1'b0;
            end
        end
    end

    // Memory array: cleared on reset, strobed byte-lane writes on an in-range commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
        end else if (w_commit && !w_aw_err) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (r_w_strb[k]) r_mem[w_aw_idx[IDX_W-1:0]][k*8 +: 8] <= r_w_data[k*8 +: 8];
            end
        end
    end

    // ---------------- B queue and output ----------------
    logic                r_bvalid;
    logic [ID_WIDTH-1:0] r_bid;
    resp_t               r_bresp;

    assign w_b_pop = (!r_bvalid || bus.bready) && !w_bq_empty;

    axi_slv_fifo #(
        .WIDTH (BQ_W),
        .DEPTH (BQ_DEPTH)
    ) u_bq (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_commit),
        .i_din   ({r_aw_id, w_aw_resp}),
        .i_pop   (w_b_pop),
        .o_dout  (w_bq_dout),
        .o_full  (w_bq_full),
        .o_empty (w_bq_empty)
    );

    // B output register: reload from the queue when free or consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bvalid <= 1'b0;
            r_bid    <= '0;
            r_bresp  <= RESP_OKAY;
        end else if (!r_bvalid || bus.bready) begin
            r_bvalid <= !w_bq_empty;
            if (!w_bq_empty) begin
                r_bid   <= w_bq_dout[BQ_W-1:2];
                r_bresp <= resp_t'(w_bq_dout[1:0]);
            end
        end
    end

    assign bus.bvalid = r_bvalid;
    assign bus.bid    = r_bid;
    assign bus.bresp  = r_bresp;
endmodule

// File: tb/tb_axi_mem_slave_ooo.sv
// Directed bench for axi_mem_slave_ooo in its default build.
// Latency: checks exact R and B latencies on the first transactions.
// Backpressure: exercises R stall, full B queue and mid-traffic reset.
module tb_axi_mem_slave_ooo;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    axi_mem_slave_ooo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    // 256 words: 0x000..0x3FC are in range, 0x400 is the first out-of-range word.
    axi_mem_slave_ooo #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .MEM_WORDS  (256),
        .RQ_DEPTH   (2),
        .BQ_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_write(input logic [31:0] addr, input logic [3:0] id,
                              input logic [31:0] data, input logic [3:0] strb);
        logic aw_done, w_done, aw_acc, w_acc;
        aw_done = 1'b0;
        w_done  = 1'b0;
        bus.awaddr = addr; bus.awid = id; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            aw_acc = bus.awvalid && bus.awready;
            w_acc  = bus.wvalid && bus.wready;
            tick();
            if (aw_acc) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
            if (w_acc)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
            if (aw_done && w_done) break;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("wr_accept", {62'd0, aw_done, w_done}, 64'd3);
    endtask

    task automatic send_read(input logic [31:0] addr, input logic [3:0] id);
        logic done, acc;
        done = 1'b0;
        bus.araddr = addr; bus.arid = id; bus.arvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            acc = bus.arvalid && bus.arready;
            tick();
            if (acc) begin done = 1'b1; break; end
        end
        bus.arvalid = 1'b0;
        check("rd_accept", {63'd0, done}, 64'd1);
    endtask

    // Wait for the next R beat (rready assumed 1), check it, consume it.
    task automatic expect_r(input string tag, input logic [31:0] data,
                            input logic [3:0] id, input logic [1:0] resp);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.rvalid) begin
                got = 1'b1;
                check({tag, "_rdata"}, 64'(bus.rdata), 64'(data));
                check({tag, "_rid"},   64'(bus.rid),   64'(id));
                check({tag, "_rresp"}, 64'(bus.rresp), 64'(resp));
                tick();
                break;
            end
            tick();
        end
        check({tag, "_rseen"}, {63'd0, got}, 64'd1);
    endtask

    task automatic expect_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.bvalid) begin
                got = 1'b1;
                check({tag, "_bid"},   64'(bus.bid),   64'(id));
                check({tag, "_bresp"}, 64'(bus.bresp), 64'(resp));
                tick();
                break;
            end
            tick();
        end
        check({tag, "_bseen"}, {63'd0, got}, 64'd1);
    endtask

    initial begin
        bus.araddr = '0; bus.arid = '0; bus.arvalid = 1'b0;
        bus.awaddr = '0; bus.awid = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.rready = 1'b1; bus.bready = 1'b1;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        check("rst_rvalid", 64'(bus.rvalid), 64'd0);
        check("rst_bvalid", 64'(bus.bvalid), 64'd0);
        check("rst_rdata",  64'(bus.rdata),  64'd0);
        check("rst_rid",    64'(bus.rid),    64'd0);
        check("rst_rresp",  64'(bus.rresp),  64'd0);
        check("rst_bid",    64'(bus.bid),    64'd0);
        check("rst_bresp",  64'(bus.bresp),  64'd0);
        rst = 1'b0;
        tick();
        check("idle_ready", {61'd0, bus.arready, bus.awready, bus.wready}, 64'd7);

        // 1: write then read with exact latencies
        send_write(32'h100, 4'd3, 32'hDEADBEEF, 4'hF);
        check("t1_b_lat0", 64'(bus.bvalid), 64'd0);
        tick();
        check("t1_b_lat1", 64'(bus.bvalid), 64'd0);
        tick();
        check("t1_bvalid", 64'(bus.bvalid), 64'd1);
        check("t1_bid",    64'(bus.bid),    64'd3);
        check("t1_bresp",  64'(bus.bresp),  64'd0);
        tick();
        send_read(32'h100, 4'd5);
        check("t1_r_lat0", 64'(bus.rvalid), 64'd0);
        tick();
        check("t1_rvalid", 64'(bus.rvalid), 64'd1);
        check("t1_rdata",  64'(bus.rdata),  64'hDEADBEEF);
        check("t1_rid",    64'(bus.rid),    64'd5);
        check("t1_rresp",  64'(bus.rresp),  64'd0);
        tick();

        // 2: partial strobe merge
        send_write(32'h104, 4'd1, 32'h11223344, 4'hF);
        expect_b("t2_w0", 4'd1, 2'b00);
        send_write(32'h104, 4'd1, 32'hAABBCCDD, 4'b0101);
        expect_b("t2_w1", 4'd1, 2'b00);
        send_read(32'h104, 4'd1);
        expect_r("t2_rd", 32'h11BB33DD, 4'd1, 2'b00);

        // 3: ids 2,2,7 under R stall; rr pointer is 2 here, so id2#0 loads first,
        //    then the scan from 3 reaches 7 before wrapping to the second id2 beat.
        bus.rready = 1'b0;
        send_read(32'h100, 4'd2);
        send_read(32'h104, 4'd2);
        send_read(32'h000, 4'd7);
        for (int k = 0; k < 5; k++) begin
            check("t3_stall_vld",  64'(bus.rvalid), 64'd1);
            check("t3_stall_data", 64'(bus.rdata),  64'hDEADBEEF);
            check("t3_stall_id",   64'(bus.rid),    64'd2);
            tick();
        end
        bus.rready = 1'b1;
        expect_r("t3_r0", 32'hDEADBEEF, 4'd2, 2'b00);
        expect_r("t3_r1", 32'h00000000, 4'd7, 2'b00);
        expect_r("t3_r2", 32'h11BB33DD, 4'd2, 2'b00);

        // 4: out-of-range accesses (0x500 would alias onto 0x100 if unchecked)
        send_read(32'h400, 4'd4);
        expect_r("t4_rd400", 32'h0, 4'd4, 2'b10);
        send_read(32'h500, 4'd4);
        expect_r("t4_rd500", 32'h0, 4'd4, 2'b10);
        send_write(32'h400, 4'd6, 32'hFFFFFFFF, 4'hF);
        expect_b("t4_wr400", 4'd6, 2'b10);
        send_read(32'h000, 4'd0);
        expect_r("t4_word0", 32'h0, 4'd0, 2'b00);

        // 5: B queue full: 1 in B register + 4 queued, 6th parked in holding regs
        bus.bready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_write(32'h10 + 32'(4 * i), 4'(8 + i), 32'h10000000 + 32'(i), 4'hF);
        end
        tick(); tick();
        check("t5_awready", 64'(bus.awready), 64'd0);
        check("t5_wready",  64'(bus.wready),  64'd0);
        check("t5_bvalid",  64'(bus.bvalid),  64'd1);
        check("t5_bid_hd",  64'(bus.bid),     64'd8);
        bus.bready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_b("t5_drain", 4'(8 + i), 2'b00);
        end
        send_read(32'h24, 4'd9);
        expect_r("t5_rd24", 32'h10000005, 4'd9, 2'b00);

        // 6: reset with traffic outstanding
        bus.rready = 1'b0;
        bus.bready = 1'b0;
        send_write(32'h200, 4'd6, 32'h55AA55AA, 4'hF);
        send_read(32'h100, 4'd0);
        send_read(32'h100, 4'd1);
        send_read(32'h100, 4'd2);
        check("t6_pre_rvalid", 64'(bus.rvalid), 64'd1);
        check("t6_pre_bvalid", 64'(bus.bvalid), 64'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_rvalid", 64'(bus.rvalid), 64'd0);
        check("t6_rst_bvalid", 64'(bus.bvalid), 64'd0);
        check("t6_rst_rdata",  64'(bus.rdata),  64'd0);
        rst = 1'b0;
        bus.rready = 1'b1;
        bus.bready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_no_stale", {62'd0, bus.rvalid, bus.bvalid}, 64'd0);
        end
        send_read(32'h100, 4'd3);
        expect_r("t6_rd100", 32'h0, 4'd3, 2'b00);
        send_read(32'h200, 4'd3);
        expect_r("t6_rd200", 32'h0, 4'd3, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
